// File: rtl/neur_event_aer_tx_if.sv
// AER output bus: the transmitter drives REQ/ADDR and the off-chip receiver returns ACK.
interface neur_event_aer_tx_if #(
  parameter int M = 8
);
  logic         AEROUT_REQ;
  logic [M-1:0] AEROUT_ADDR;
  logic         AEROUT_ACK;

  modport master (output AEROUT_REQ, output AEROUT_ADDR, input AEROUT_ACK);
  modport slave  (input AEROUT_REQ, input AEROUT_ADDR, output AEROUT_ACK);
endinterface

// File: rtl/neur_event_aer_tx.sv
// Spike event capture FIFO feeding a four-phase AER transmitter; bursts expand into
// repeated transactions on one address, and overflow is counted rather than stalling the core.
module neur_event_aer_tx #(
  parameter int M       = 8,
  parameter int FIFO_AW = 3
) (
  input  logic                  CLK,
  input  logic                  RST_sync,
  input  logic                  SPI_GATE_ACTIVITY_sync,
  input  logic                  CTRL_NEURMEM_CS,
  input  logic                  CTRL_NEURMEM_WE,
  input  logic [M-1:0]          CTRL_NEURMEM_ADDR,
  input  logic [6:0]            NEUR_EVENT_OUT,
  neur_event_aer_tx_if.master   aer,
  output logic                  EVT_FIFO_EMPTY,
  output logic                  EVT_OVERFLOW,
  output logic [7:0]            EVT_DROP_CNT
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int E_W   = M + 3;
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKLOW} state_e;

  state_e             state_q;
  logic [E_W-1:0]     mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [M-1:0]       tx_addr_q;
  logic [2:0]         rem_q;
  logic               req_q;
  logic               ack_meta_q, ack_s_q;
  logic               ovf_q;
  logic [7:0]         drop_cnt_q;

  logic           capture, full, push, pop, drop;
  logic [E_W-1:0] entry, head;
  logic           unused_evt_bits;

  assign unused_evt_bits = ^NEUR_EVENT_OUT[5:3];

  assign capture = CTRL_NEURMEM_CS & CTRL_NEURMEM_WE & NEUR_EVENT_OUT[6] & ~SPI_GATE_ACTIVITY_sync;
  assign entry   = {CTRL_NEURMEM_ADDR, NEUR_EVENT_OUT[2:0]};
  // Full uses the registered count so a same-cycle pop never rescues a capture into a full FIFO.
  assign full    = (cnt_q == CNT_FULL);
  assign push    = capture & ~full;
  assign drop    = capture & full;
  assign pop     = (state_q == S_IDLE) && (cnt_q != '0);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  always_ff @(posedge CLK) begin
    if (RST_sync) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q      <= cnt_d;
      ack_meta_q <= aer.AEROUT_ACK;
      ack_s_q    <= ack_meta_q;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // TX FSM: one entry expands into 1 + burst handshakes on the same address.
  always_ff @(posedge CLK) begin
    if (RST_sync) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      tx_addr_q <= '0;
      rem_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (pop) begin
          tx_addr_q <= head[E_W-1:3];
          rem_q     <= head[2:0];
          req_q     <= 1'b1;
          state_q   <= S_REQ;
        end
        S_REQ: if (ack_s_q) begin
          req_q   <= 1'b0;
          state_q <= S_ACKLOW;
        end
        S_ACKLOW: if (!ack_s_q) begin
          if (rem_q != 3'd0) begin
            rem_q   <= rem_q - 3'd1;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign aer.AEROUT_REQ  = req_q;
  assign aer.AEROUT_ADDR = tx_addr_q;
  assign EVT_FIFO_EMPTY  = (cnt_q == '0);
  assign EVT_OVERFLOW    = ovf_q;
  assign EVT_DROP_CNT    = drop_cnt_q;
endmodule

// File: doc/neur_event_aer_tx.md
# neur_event_aer_tx

Output spike transmitter sitting directly downstream of the neuron core. It captures each output spike event the core produces during a neuron-memory write, buffers it in a small FIFO, and serialises it onto the off-chip AER output bus with a four-phase REQ/ACK handshake. A burst event expands into several consecutive AER transactions carrying the same neuron address. Overflow is counted, never back-propagated, so the neuron update pipeline never stalls.

## Interface
- M, 8, neuron address width (2^M neurons)
- FIFO_AW, 3, FIFO address width (depth 2^FIFO_AW = 8 entries)

- CLK  in  1  system clock; all state on rising edge
- RST_sync  in  1  synchronous reset, active-high
- SPI_GATE_ACTIVITY_sync  in  1  configuration mode; when high, no events are captured
- CTRL_NEURMEM_CS  in  1  neuron memory chip select
- CTRL_NEURMEM_WE  in  1  neuron memory write enable
- CTRL_NEURMEM_ADDR  in  M  address of the neuron being written back
- NEUR_EVENT_OUT  in  7  core output event; [6] spike flag, [5:3] ignored, [2:0] extra spikes in the burst
- AEROUT_ACK  in  1  AER acknowledge, asynchronous to CLK
- AEROUT_REQ  out  1  AER request, registered
- AEROUT_ADDR  out  M  AER address (neuron index), registered
- EVT_FIFO_EMPTY  out  1  FIFO holds no entry
- EVT_OVERFLOW  out  1  sticky; set on first dropped event
- EVT_DROP_CNT  out  8  saturating count of dropped events

## Operation
- Capture condition, evaluated each cycle: CTRL_NEURMEM_CS & CTRL_NEURMEM_WE & NEUR_EVENT_OUT[6] & ~SPI_GATE_ACTIVITY_sync.
- Captured entry is {CTRL_NEURMEM_ADDR, NEUR_EVENT_OUT[2:0]}, M+3 bits.
- FIFO: circular, with wr/rd pointers of FIFO_AW bits and a count of FIFO_AW+1 bits. Full when count = 2^FIFO_AW. Pointers wrap modulo depth.
- Full is judged on the registered count. If a capture occurs while full, the entry is dropped even if a pop happens in the same cycle. A drop sets EVT_OVERFLOW and increments EVT_DROP_CNT, which saturates at 255.
- Push and pop in the same cycle on a non-full FIFO: both take effect and the count is unchanged.
- AEROUT_ACK passes through a 2-flop synchronizer; ack_s is the second flop's output.
- TX FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, load tx_addr and rem = burst field, go to REQ.
  - REQ: AEROUT_REQ = 1. When ack_s = 1, go to ACKLOW.
  - ACKLOW: AEROUT_REQ = 0. When ack_s = 0: if rem ≠ 0, decrement rem and go to REQ; otherwise go to IDLE.
- Each entry therefore produces 1 + burst field AER transactions (1 to 8), all with the same address.
- AEROUT_ADDR is driven from tx_addr. It is stable from the REQ rising edge until the ACKLOW exit.
- Reset values: AEROUT_REQ = 0, AEROUT_ADDR = 0, EVT_FIFO_EMPTY = 1, EVT_OVERFLOW = 0, EVT_DROP_CNT = 0, FSM in IDLE, pointers/count/rem = 0, synchronizer flops = 0.
- Reset mid-handshake: REQ goes low on the reset edge and buffered events are discarded. A truncated handshake is acceptable to the receiver.
- EVT_OVERFLOW and EVT_DROP_CNT are cleared only by RST_sync.

## Timing
- Capture at edge t: the count updates at t, and EVT_FIFO_EMPTY is low from t.
- Idle FSM with an empty FIFO: the pop and the tx_addr load happen at edge t+1. AEROUT_REQ and AEROUT_ADDR are valid after edge t+1, i.e. 1 cycle of capture-to-REQ latency.
- ACK rising and sampled at edge a: ack_s is high after a+1, the FSM moves to ACKLOW at a+2, and REQ is low after a+2.
- ACK falling: same 2-edge latency to the next REQ rise within a burst, or to IDLE.
- Minimum per-transaction turnaround, with ACK tied to REQ: 6 cycles. IDLE adds 1 cycle between FIFO entries.
- Sustained capture rate above the drain rate fills the FIFO after 8 entries plus the one entry held in the TX registers.

## Test plan
- Single spike on address 0x2A, burst = 0, ACK responder with 2-cycle delay: one REQ pulse with AEROUT_ADDR = 0x2A, EVT_FIFO_EMPTY returns to 1, and EVT_DROP_CNT = 0.
- Burst: event on address 0x05 with [2:0] = 3: exactly 4 complete REQ/ACK handshakes, all with address 0x05, then IDLE.
- Overflow: ACK held low and 12 spikes captured on consecutive cycles (addresses 0..11): 9 are retained (1 in TX plus 8 in the FIFO) and EVT_DROP_CNT = 3. After ACK is released, addresses 0..8 are output in order and EVT_OVERFLOW stays 1.
- Gating: SPI_GATE_ACTIVITY_sync = 1 with CS = WE = 1 and a spike flag set: nothing is captured, EVT_FIFO_EMPTY stays 1, and REQ stays 0.
- Simultaneous push and pop: a new spike lands in the same cycle the FSM pops the head. The count is unchanged and order is preserved. With the FIFO full, the same push is dropped and EVT_DROP_CNT increments.
- Reset asserted while REQ = 1 and 4 entries are buffered: the next edge gives REQ = 0, EVT_FIFO_EMPTY = 1, and all counters = 0. No REQ occurs after reset is released.
